// File: rtl/dmu_sio_rx_assembler.sv
// SIU-to-DMU outbound receiver: assembles header + optional 4-beat payload,
// checks per-lane parity and queues complete packets for the DMU consumer.
module dmu_sio_rx_assembler #(
    parameter int DEPTH      = 2,
    parameter int PERR_CNT_W = 16
) (
    input  logic                  iol2clk,
    input  logic                  rst,
    input  logic                  sio_dmu_hdr_vld,
    input  logic                  sio_dmu_datareq,
    input  logic [127:0]          sio_dmu_data,
    input  logic [7:0]            sio_dmu_parity,
    output logic                  pkt_vld,
    input  logic                  pkt_rdy,
    output logic [127:0]          pkt_hdr,
    output logic                  pkt_has_data,
    output logic [511:0]          pkt_data,
    output logic [3:0]            pkt_par_err,
    input  logic                  err_clr,
    output logic                  ovf_err,
    output logic                  proto_err,
    output logic [PERR_CNT_W-1:0] perr_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_PAY, S_DROP} state_t;

    state_t                  r_state;
    logic [1:0]              r_beat_cnt;
    logic [127:0]            r_asm_hdr;
    logic [383:0]            r_asm_data;
    logic [2:0]              r_asm_perr;
    logic                    r_ovf_err;
    logic                    r_proto_err;
    logic [PERR_CNT_W-1:0]   r_perr_cnt;

    logic [127:0]            r_fifo_hdr  [DEPTH];
    logic                    r_fifo_has  [DEPTH];
    logic [511:0]            r_fifo_data [DEPTH];
    logic [3:0]              r_fifo_perr [DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;

    logic                    w_pop;
    logic                    w_slot_free;
    logic                    w_beat_perr;
    logic                    w_last_beat;
    logic                    w_push;
    logic [127:0]            w_push_hdr;
    logic [511:0]            w_push_data;
    logic [3:0]              w_push_perr;
    logic                    w_perr_evt;
    logic                    w_ovf_evt;
    logic                    w_proto_evt;

    always_comb begin
        w_beat_perr = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_beat_perr = w_beat_perr | (^{sio_dmu_data[16*i +: 16], sio_dmu_parity[i]});
        end
    end

    // A pop in the same cycle frees the slot for an incoming header.
    assign w_pop       = (r_count != '0) & pkt_rdy;
    assign w_slot_free = (r_count < CNT_W'(DEPTH)) | w_pop;
    assign w_last_beat = (r_state == S_PAY) & ~sio_dmu_hdr_vld & (r_beat_cnt == 2'd3);
    assign w_push      = (sio_dmu_hdr_vld & w_slot_free & ~sio_dmu_datareq) | w_last_beat;
    assign w_push_hdr  = sio_dmu_hdr_vld ? sio_dmu_data : r_asm_hdr;
    assign w_push_data = w_last_beat ? {sio_dmu_data, r_asm_data} : '0;
    assign w_push_perr = w_last_beat ? {w_beat_perr, r_asm_perr} : '0;
    assign w_perr_evt  = (r_state == S_PAY) & ~sio_dmu_hdr_vld & w_beat_perr;
    assign w_ovf_evt   = sio_dmu_hdr_vld & ~w_slot_free;
    assign w_proto_evt = sio_dmu_hdr_vld & (r_state != S_IDLE);

    always_ff @(posedge iol2clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_asm_hdr  <= '0;
            r_asm_data <= '0;
            r_asm_perr <= '0;
        end else if (sio_dmu_hdr_vld) begin
            // A header in any state restarts assembly; the partial packet is dropped.
            r_beat_cnt <= '0;
            if (w_slot_free) begin
                r_asm_hdr <= sio_dmu_data;
                r_state   <= sio_dmu_datareq ? S_PAY : S_IDLE;
            end else begin
                r_state   <= sio_dmu_datareq ? S_DROP : S_IDLE;
            end
        end else begin
            case (r_state)
                S_PAY: begin
                    case (r_beat_cnt)
                        2'd0: begin
                            r_asm_data[127:0]   <= sio_dmu_data;
                            r_asm_perr[0]       <= w_beat_perr;
                        end
                        2'd1: begin
                            r_asm_data[255:128] <= sio_dmu_data;
                            r_asm_perr[1]       <= w_beat_perr;
                        end
                        2'd2: begin
                            r_asm_data[383:256] <= sio_dmu_data;
                            r_asm_perr[2]       <= w_beat_perr;
                        end
                        default: ;
                    endcase
                    r_beat_cnt <= r_beat_cnt + 2'd1;
                    if (r_beat_cnt == 2'd3) r_state <= S_IDLE;
                end
                S_DROP: begin
                    r_beat_cnt <= r_beat_cnt + 2'd1;
                    if (r_beat_cnt == 2'd3) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // New error events take priority over a coincident clear.
    always_ff @(posedge iol2clk) begin
        if (rst) begin
            r_ovf_err   <= 1'b0;
            r_proto_err <= 1'b0;
            r_perr_cnt  <= '0;
        end else begin
            if (w_ovf_evt)        r_ovf_err   <= 1'b1;
            else if (err_clr)     r_ovf_err   <= 1'b0;
            if (w_proto_evt)      r_proto_err <= 1'b1;
            else if (err_clr)     r_proto_err <= 1'b0;
            if (w_perr_evt) begin
                if (err_clr)                r_perr_cnt <= PERR_CNT_W'(1);
                else if (r_perr_cnt != '1)  r_perr_cnt <= r_perr_cnt + PERR_CNT_W'(1);
            end else if (err_clr) begin
                r_perr_cnt <= '0;
            end
        end
    end

    always_ff @(posedge iol2clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_fifo_hdr[i]  <= '0;
                r_fifo_has[i]  <= 1'b0;
                r_fifo_data[i] <= '0;
                r_fifo_perr[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_hdr[r_wr_ptr]  <= w_push_hdr;
                r_fifo_has[r_wr_ptr]  <= w_last_beat;
                r_fifo_data[r_wr_ptr] <= w_push_data;
                r_fifo_perr[r_wr_ptr] <= w_push_perr;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign pkt_vld      = (r_count != '0);
    assign pkt_hdr      = r_fifo_hdr[r_rd_ptr];
    assign pkt_has_data = r_fifo_has[r_rd_ptr];
    assign pkt_data     = r_fifo_data[r_rd_ptr];
    assign pkt_par_err  = r_fifo_perr[r_rd_ptr];
    assign ovf_err      = r_ovf_err;
    assign proto_err    = r_proto_err;
    assign perr_cnt     = r_perr_cnt;

endmodule

// File: tb/tb_dmu_sio_rx_assembler.sv
// Bench for dmu_sio_rx_assembler: directed and random traffic checked against
// a packet-level reference model (expected-packet queue plus error state).
module tb_dmu_sio_rx_assembler;

    localparam int DEPTH = 2;
    localparam int PW    = 16;

    logic           iol2clk = 1'b0;
    logic           rst = 1'b1;
    logic           sio_dmu_hdr_vld = 1'b0;
    logic           sio_dmu_datareq = 1'b0;
    logic [127:0]   sio_dmu_data = '0;
    logic [7:0]     sio_dmu_parity = '0;
    logic           pkt_vld;
    logic           pkt_rdy = 1'b0;
    logic [127:0]   pkt_hdr;
    logic           pkt_has_data;
    logic [511:0]   pkt_data;
    logic [3:0]     pkt_par_err;
    logic           err_clr = 1'b0;
    logic           ovf_err;
    logic           proto_err;
    logic [PW-1:0]  perr_cnt;

    always #5 iol2clk = ~iol2clk;

    dmu_sio_rx_assembler #(.DEPTH(DEPTH), .PERR_CNT_W(PW)) dut (
        .iol2clk(iol2clk), .rst(rst),
        .sio_dmu_hdr_vld(sio_dmu_hdr_vld), .sio_dmu_datareq(sio_dmu_datareq),
        .sio_dmu_data(sio_dmu_data), .sio_dmu_parity(sio_dmu_parity),
        .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .pkt_hdr(pkt_hdr),
        .pkt_has_data(pkt_has_data), .pkt_data(pkt_data), .pkt_par_err(pkt_par_err),
        .err_clr(err_clr), .ovf_err(ovf_err), .proto_err(proto_err), .perr_cnt(perr_cnt)
    );

    typedef struct {
        logic [127:0] hdr;
        logic         has;
        logic [511:0] data;
        logic [3:0]   perr;
    } pkt_t;

    pkt_t          q[$];
    pkt_t          m_cur;
    int            m_left = 0;
    bit            m_acc = 0;
    bit            m_ovf = 0;
    bit            m_proto = 0;
    logic [PW-1:0] m_cnt = '0;
    bit            rnd_mode = 0;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [7:0] good_par(input logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Applies the current input cycle to the reference model.
    task automatic model_step();
        bit   pop;
        bit   room;
        bit   err;
        int   idx;
        pkt_t p;
        if (rst) begin
            q.delete();
            m_left = 0; m_ovf = 0; m_proto = 0; m_cnt = '0;
            return;
        end
        pop  = (q.size() > 0) && pkt_rdy;
        room = (q.size() < DEPTH) || pop;
        if (err_clr) begin
            m_ovf = 0; m_proto = 0; m_cnt = '0;
        end
        if (pop) void'(q.pop_front());
        if (sio_dmu_hdr_vld) begin
            if (m_left > 0) m_proto = 1;
            m_left = 0;
            if (room) begin
                if (sio_dmu_datareq) begin
                    m_left = 4; m_acc = 1;
                    m_cur.hdr = sio_dmu_data; m_cur.has = 1'b1;
                    m_cur.data = '0; m_cur.perr = '0;
                end else begin
                    p.hdr = sio_dmu_data; p.has = 1'b0; p.data = '0; p.perr = '0;
                    q.push_back(p);
                end
            end else begin
                m_ovf = 1;
                if (sio_dmu_datareq) begin
                    m_left = 4; m_acc = 0;
                end
            end
        end else if (m_left > 0) begin
            idx = 4 - m_left;
            if (m_acc) begin
                err = (sio_dmu_parity != good_par(sio_dmu_data));
                m_cur.data[128*idx +: 128] = sio_dmu_data;
                m_cur.perr[idx] = err;
                if (err && m_cnt != '1) m_cnt = m_cnt + 1'b1;
            end
            m_left--;
            if (m_left == 0 && m_acc) q.push_back(m_cur);
        end
    endtask

    task automatic check_all();
        chk("vld", pkt_vld, q.size() != 0);
        if (q.size() != 0) begin
            chk("hdr", pkt_hdr, q[0].hdr);
            chk("has_data", pkt_has_data, q[0].has);
            chk("data", pkt_data, q[0].data);
            chk("par_err", pkt_par_err, q[0].perr);
        end
        chk("ovf_err", ovf_err, m_ovf);
        chk("proto_err", proto_err, m_proto);
        chk("perr_cnt", perr_cnt, m_cnt);
    endtask

    task automatic tick();
        if (rnd_mode) begin
            pkt_rdy = ($urandom_range(0, 3) != 0);
            err_clr = ($urandom_range(0, 15) == 0);
        end
        model_step();
        @(posedge iol2clk);
        #1;
        check_all();
    endtask

    task automatic hdr(input logic [127:0] h, input logic dreq);
        sio_dmu_hdr_vld = 1'b1; sio_dmu_datareq = dreq;
        sio_dmu_data = h; sio_dmu_parity = 8'($urandom);
        tick();
    endtask

    task automatic beat(input logic [127:0] d, input logic [7:0] flip);
        sio_dmu_hdr_vld = 1'b0; sio_dmu_datareq = 1'b0;
        sio_dmu_data = d; sio_dmu_parity = good_par(d) ^ flip;
        tick();
    endtask

    task automatic idle();
        sio_dmu_hdr_vld = 1'b0; sio_dmu_datareq = 1'b0;
        sio_dmu_data = rnd128(); sio_dmu_parity = 8'($urandom);
        tick();
    endtask

    function automatic logic [7:0] rnd_flip();
        return ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
    endfunction

    initial begin
        logic [127:0] h1, h2, h3;
        int k;

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_vld", pkt_vld, 1'b0);
        chk("rst_hdr", pkt_hdr, 128'h0);
        chk("rst_has", pkt_has_data, 1'b0);
        chk("rst_data", pkt_data, 512'h0);
        chk("rst_perr", pkt_par_err, 4'h0);
        chk("rst_flags", {ovf_err, proto_err}, 2'b00);
        chk("rst_cnt", perr_cnt, 16'h0);

        // Basic data packet
        pkt_rdy = 1'b0;
        hdr(128'h0123_4567_89AB_CDEF_0011_2233_4455_66A5, 1'b1);
        beat({4{32'h11111111}}, 8'h00);
        beat({4{32'h22222222}}, 8'h00);
        beat({4{32'h33333333}}, 8'h00);
        beat({4{32'h44444444}}, 8'h00);
        chk("t1_vld", pkt_vld, 1'b1);
        chk("t1_lo", pkt_data[127:0], {4{32'h11111111}});
        chk("t1_hi", pkt_data[511:384], {4{32'h44444444}});
        chk("t1_perr", pkt_par_err, 4'b0000);
        chk("t1_cnt", perr_cnt, 16'd0);
        pkt_rdy = 1'b1;
        idle();

        // Parity error on beat 2
        pkt_rdy = 1'b0;
        hdr(128'h0123_4567_89AB_CDEF_0011_2233_4455_66A5, 1'b1);
        beat({4{32'h11111111}}, 8'h00);
        beat({4{32'h22222222}}, 8'h00);
        beat({4{32'h33333333}}, 8'h08);
        beat({4{32'h44444444}}, 8'h00);
        chk("t2_perr", pkt_par_err, 4'b0100);
        chk("t2_cnt", perr_cnt, 16'd1);
        chk("t2_vld", pkt_vld, 1'b1);
        pkt_rdy = 1'b1;
        idle();

        // Overflow with consumer stalled
        pkt_rdy = 1'b0;
        h1 = rnd128(); h2 = rnd128(); h3 = rnd128();
        hdr(h1, 1'b0); hdr(h2, 1'b0); hdr(h3, 1'b0);
        chk("t3_ovf", ovf_err, 1'b1);
        chk("t3_head", pkt_hdr, h1);
        pkt_rdy = 1'b1;
        idle();
        chk("t3_second", pkt_hdr, h2);
        idle();
        chk("t3_empty", pkt_vld, 1'b0);
        err_clr = 1'b1; idle(); err_clr = 1'b0;
        chk("t3_clr", ovf_err, 1'b0);

        // Header interrupting payload at beat 2
        pkt_rdy = 1'b0;
        h1 = rnd128(); h2 = rnd128();
        hdr(h1, 1'b1);
        beat(rnd128(), 8'h00);
        beat(rnd128(), 8'h00);
        hdr(h2, 1'b0);
        chk("t4_proto", proto_err, 1'b1);
        chk("t4_hdr", pkt_hdr, h2);
        chk("t4_has", pkt_has_data, 1'b0);
        pkt_rdy = 1'b1;
        idle();
        chk("t4_only_one", pkt_vld, 1'b0);
        err_clr = 1'b1; idle(); err_clr = 1'b0;

        // Full buffer with same-cycle pop accepts new header
        pkt_rdy = 1'b0;
        hdr(rnd128(), 1'b0); hdr(rnd128(), 1'b0);
        pkt_rdy = 1'b1;
        h3 = rnd128();
        hdr(h3, 1'b0);
        chk("t5_ovf", ovf_err, 1'b0);
        idle(); idle(); idle();

        // Randomised traffic
        rnd_mode = 1;
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            if (k <= 3) begin
                hdr(rnd128(), 1'b0);
            end else if (k <= 7) begin
                hdr(rnd128(), 1'b1);
                for (int b = 0; b < 4; b++) beat(rnd128(), rnd_flip());
            end else if (k == 8) begin
                hdr(rnd128(), 1'b1);
                for (int b = 0; b < int'($urandom_range(0, 3)); b++) beat(rnd128(), rnd_flip());
                hdr(rnd128(), 1'b0);
            end else begin
                idle();
            end
        end
        rnd_mode = 0;
        err_clr = 1'b0;
        pkt_rdy = 1'b1;
        idle(); idle(); idle();

        // Clear coinciding with error events
        hdr(rnd128(), 1'b1);
        beat(rnd128(), 8'h40);
        err_clr = 1'b1;
        beat(rnd128(), 8'h02);
        err_clr = 1'b0;
        chk("clr_vs_perr", perr_cnt, 16'd1);
        beat(rnd128(), 8'h00);
        err_clr = 1'b1;
        hdr(rnd128(), 1'b0);
        err_clr = 1'b0;
        chk("clr_vs_proto", proto_err, 1'b1);
        idle(); idle();

        // Counter saturation
        err_clr = 1'b1; idle(); err_clr = 1'b0;
        for (int n = 0; n < 16385; n++) begin
            hdr(rnd128(), 1'b1);
            for (int b = 0; b < 4; b++) beat(rnd128(), 8'h01);
        end
        chk("sat_cnt", perr_cnt, 16'hFFFF);
        err_clr = 1'b1; idle(); err_clr = 1'b0;
        chk("sat_clr", perr_cnt, 16'h0);

        // Reset mid-packet discards buffered and partial packets
        pkt_rdy = 1'b0;
        hdr(rnd128(), 1'b0);
        hdr(rnd128(), 1'b1);
        beat(rnd128(), 8'h00);
        rst = 1'b1;
        beat(rnd128(), 8'h00);
        rst = 1'b0;
        chk("rst_mid_vld", pkt_vld, 1'b0);
        h1 = rnd128();
        hdr(h1, 1'b1);
        for (int b = 0; b < 4; b++) beat(rnd128(), 8'h00);
        chk("post_rst_vld", pkt_vld, 1'b1);
        chk("post_rst_hdr", pkt_hdr, h1);
        pkt_rdy = 1'b1;
        idle(); idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
